// File: rtl/anc_frame_scheduler.sv
// Per-frame sequencer between the I2S2 AXIS controller and the ANC filter core:
// accept a stereo RX packet, run the filter (or bypass), emit the result as a stereo TX packet.
module anc_frame_scheduler #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 400
) (
  input  logic              axis_clk,
  input  logic              axis_reset,
  input  logic [31:0]       rx_axis_s_data,
  input  logic              rx_axis_s_valid,
  output logic              rx_axis_s_ready,
  input  logic              rx_axis_s_last,
  output logic [31:0]       tx_axis_m_data,
  output logic              tx_axis_m_valid,
  input  logic              tx_axis_m_ready,
  output logic              tx_axis_m_last,
  input  logic              bypass,
  output logic              filt_start,
  output logic [DATA_W-1:0] filt_ref,
  output logic [DATA_W-1:0] filt_err,
  input  logic              filt_done,
  input  logic [DATA_W-1:0] filt_out,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        timeout_cnt,
  output logic [7:0]        pkt_err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int PAD_W = 32 - DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_RX_L, S_RX_R, S_START, S_WAIT, S_TX_L, S_TX_R} state_e;

  state_e             state_q, state_d;
  logic               rx_ready_q, rx_ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic               start_q, start_d;
  logic [DATA_W-1:0]  ref_q, err_q, held_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        frame_q;
  logic [7:0]         tout_q, perr_q;
  logic               rx_hs, tx_hs, wait_expired;
  logic               rx_data_unused;

  assign rx_hs          = rx_axis_s_valid & rx_ready_q;
  assign tx_hs          = tx_valid_q & tx_axis_m_ready;
  assign wait_expired   = (cnt_q == CNT_LAST);
  assign rx_data_unused = ^rx_axis_s_data[31:DATA_W];

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the same pre-edge values regardless of process ordering.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q    <= S_RX_L;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      start_q    <= start_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RX_L:  if (rx_hs && !rx_axis_s_last) state_d = S_RX_R;
      S_RX_R:  if (rx_hs && rx_axis_s_last)  state_d = bypass ? S_TX_L : S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (filt_done || wait_expired) state_d = S_TX_L;
      S_TX_L:  if (tx_hs) state_d = S_TX_R;
      S_TX_R:  if (tx_hs) state_d = S_RX_L;
      default: state_d = S_RX_L;
    endcase
  end

  // Handshake outputs are decoded from the next state and registered, so no
  // combinational path exists from valid to ready or from done to start.
  always_comb begin
    rx_ready_d = (state_d == S_RX_L) || (state_d == S_RX_R);
    tx_valid_d = (state_d == S_TX_L) || (state_d == S_TX_R);
    tx_last_d  = (state_d == S_TX_R);
    start_d    = (state_d == S_START);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      ref_q   <= '0;
      err_q   <= '0;
      held_q  <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      tout_q  <= '0;
      perr_q  <= '0;
    end else begin
      unique case (state_q)
        S_RX_L: if (rx_hs) begin
          if (!rx_axis_s_last) ref_q <= rx_axis_s_data[DATA_W-1:0];
          else if (perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
        end
        S_RX_R: if (rx_hs) begin
          if (rx_axis_s_last) begin
            err_q <= rx_axis_s_data[DATA_W-1:0];
            if (bypass) held_q <= ref_q;
          end else begin
            ref_q <= rx_axis_s_data[DATA_W-1:0];
            if (perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
          end
        end
        S_START: cnt_q <= '0;
        S_WAIT: begin
          // Done wins over a coincident timeout; on timeout the last good sample is resent.
          if (filt_done) held_q <= filt_out;
          else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (wait_expired && tout_q != 8'hFF) tout_q <= tout_q + 8'd1;
          end
        end
        S_TX_R: if (tx_hs) frame_q <= frame_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign rx_axis_s_ready = rx_ready_q;
  assign tx_axis_m_valid = tx_valid_q;
  assign tx_axis_m_last  = tx_last_q;
  assign tx_axis_m_data  = {{PAD_W{1'b0}}, held_q};
  assign filt_start      = start_q;
  assign filt_ref        = ref_q;
  assign filt_err        = err_q;
  assign frame_cnt       = frame_q;
  assign timeout_cnt     = tout_q;
  assign pkt_err_cnt     = perr_q;

endmodule
